// File: rtl/dvfs_pkg.sv
// Shared DVFS types and defaults: performance level encoding, sequencer states
// and settle/timeout cycle counts used by the sequencer and dvfs_controller.
package dvfs_pkg;

    typedef logic [1:0] level_t;

    localparam level_t LEVEL_MIN = 2'd0;
    localparam level_t LEVEL_MAX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_WAIT,
        ST_V_SETTLE,
        ST_F_WAIT,
        ST_DONE
    } state_t;

    localparam int VSETTLE_DEFAULT = 16;
    localparam int FSETTLE_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dvfs_settle_timer.sv
// Loadable down-counter shared by all wait/settle states of the sequencer.
// Counts down every cycle after a load and sticks at zero; zero means expired.
module dvfs_settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Orders voltage/frequency select changes so volt_sel never drops below freq_sel:
// voltage rises before frequency, frequency falls before voltage.
module dvfs_transition_sequencer
    import dvfs_pkg::*;
#(
    parameter int VSETTLE_CYCLES = VSETTLE_DEFAULT,
    parameter int FSETTLE_CYCLES = FSETTLE_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_level,
    output logic       req_ready,
    input  logic       vreg_ack,
    output logic [1:0] freq_sel,
    output logic [1:0] volt_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TW = $clog2(max3(VSETTLE_CYCLES, FSETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
    // Settle loads are one less than the cycle count because the entry edge is the load;
    // the timeout load is not, so the abort lands on edge 1+TIMEOUT after V_WAIT entry.
    localparam logic [TW-1:0] LD_VSETTLE = TW'(VSETTLE_CYCLES - 1);
    localparam logic [TW-1:0] LD_FSETTLE = TW'(FSETTLE_CYCLES - 1);
    localparam logic [TW-1:0] LD_TIMEOUT = TW'(TIMEOUT_CYCLES);

    state_t      r_state, w_state_nx;
    level_t      r_freq, w_freq_nx;
    level_t      r_volt, w_volt_nx;
    level_t      r_target, w_target_nx;
    logic        r_up, w_up_nx;
    logic        r_err, w_err_nx;
    logic        w_tmr_load;
    logic [TW-1:0] w_tmr_value;
    logic        w_tmr_expired;

    dvfs_settle_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_tmr_load),
        .i_value  (w_tmr_value),
        .o_expired(w_tmr_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_freq   <= LEVEL_MIN;
            r_volt   <= LEVEL_MIN;
            r_target <= LEVEL_MIN;
            r_up     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_freq   <= w_freq_nx;
            r_volt   <= w_volt_nx;
            r_target <= w_target_nx;
            r_up     <= w_up_nx;
            r_err    <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_freq_nx   = r_freq;
        w_volt_nx   = r_volt;
        w_target_nx = r_target;
        w_up_nx     = r_up;
        w_err_nx    = r_err;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_err_nx    = 1'b0;
                    w_target_nx = req_level;
                    if (req_level > r_freq) begin
                        w_up_nx     = 1'b1;
                        w_volt_nx   = req_level;
                        w_state_nx  = ST_V_WAIT;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = LD_TIMEOUT;
                    end else if (req_level < r_freq) begin
                        w_up_nx     = 1'b0;
                        w_freq_nx   = req_level;
                        w_state_nx  = ST_F_WAIT;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = LD_FSETTLE;
                    end else begin
                        w_state_nx  = ST_DONE;
                    end
                end
            end
            ST_V_WAIT: begin
                // Ack takes priority over a timeout expiring on the same edge.
                if (vreg_ack) begin
                    w_state_nx  = ST_V_SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = LD_VSETTLE;
                end else if (w_tmr_expired) begin
                    w_err_nx    = 1'b1;
                    w_state_nx  = ST_IDLE;
                end
            end
            ST_V_SETTLE: begin
                if (w_tmr_expired) begin
                    if (r_up) begin
                        w_freq_nx   = r_target;
                        w_state_nx  = ST_F_WAIT;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = LD_FSETTLE;
                    end else begin
                        w_state_nx  = ST_DONE;
                    end
                end
            end
            ST_F_WAIT: begin
                if (w_tmr_expired) begin
                    if (r_up) begin
                        w_state_nx  = ST_DONE;
                    end else begin
                        w_volt_nx   = r_target;
                        w_state_nx  = ST_V_WAIT;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = LD_TIMEOUT;
                    end
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign freq_sel  = r_freq;
    assign volt_sel  = r_volt;
    assign err       = r_err;

endmodule

// File: doc/dvfs_transition_sequencer.md
# dvfs_transition_sequencer

Sequences operating-point changes for the DVFS datapath: it accepts a target performance level from `dvfs_controller`'s decision logic and drives `freq_sel`/`volt_sel` to the regulator and clock generator in a safe order. Voltage goes up before frequency, and frequency goes down before voltage. Each step waits for regulator acknowledge or a settle time. The block sits between the policy logic and the physical clock/voltage selects.

## Interface
- `VSETTLE_CYCLES`, 16: cycles to hold after regulator ack before the next step (≥1).
- `FSETTLE_CYCLES`, 4: cycles to hold after a frequency change (clock switch/lock) (≥1).
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for `vreg_ack` before aborting (≥1).
- `clk`  in  1  system clock; all state changes occur on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a target level is presented.
- `req_level`  in  2  target level; 0 is the lowest frequency/voltage and 3 the highest; same encoding as `freq_sel`/`volt_sel`.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `vreg_ack`  in  1  regulator reports output settled at the current `volt_sel`; sampled only in V_WAIT.
- `freq_sel`  out  2  registered frequency select.
- `volt_sel`  out  2  registered voltage select.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a transition completes.
- `err`  out  1  sticky regulator-timeout flag; cleared when the next request is accepted.

## Operation
- Reset values: `freq_sel`=0, `volt_sel`=0, `busy`=0, `done`=0, `err`=0, state IDLE (so `req_ready`=1).
- Reset mid-transition: all outputs return to their reset values at once. Level 0 is the safe point.
- States:
  - IDLE
  - V_WAIT: `volt_sel` already updated; wait for ack.
  - V_SETTLE: count `VSETTLE_CYCLES`.
  - F_WAIT: `freq_sel` already updated; count `FSETTLE_CYCLES`.
  - DONE: `done`=1.
- A direction flag is latched at acceptance.
- Upscale (`req_level > freq_sel`):
  - At acceptance: `volt_sel` ← target, go to V_WAIT.
  - On ack: go to V_SETTLE.
  - After settle: `freq_sel` ← target, go to F_WAIT.
  - Then DONE, then IDLE.
- Downscale (`req_level < freq_sel`):
  - At acceptance: `freq_sel` ← target, go to F_WAIT.
  - After settle: `volt_sel` ← target, go to V_WAIT.
  - On ack: go to V_SETTLE.
  - Then DONE, then IDLE.
- Equal level: at acceptance go straight to DONE. No select changes; the regulator is not involved.
- Timeout: V_WAIT counts the cycles in which `vreg_ack` is sampled low.
  - After `TIMEOUT_CYCLES` such cycles: `err`←1, go to IDLE, no `done` pulse.
  - `freq_sel`/`volt_sel` hold their current values; this is always a safe pair because of the ordering.
- Ack sampled in the same cycle the timeout count expires: ack wins.
- `vreg_ack` outside V_WAIT: ignored.
- `req_valid` while busy: not accepted and not queued. The requester holds it until `req_ready`.
- `req_level` is captured only at acceptance.
- Invariant: `volt_sel ≥ freq_sel` at every clock edge.

## Timing
Edges are numbered from the acceptance edge = 0.
- Upscale, ack sampled at edge 1 (defaults):
  - `volt_sel` changes at edge 0.
  - V_SETTLE covers edges 1–17.
  - `freq_sel` changes at edge 17.
  - `done` is high from edge 21 to edge 22.
  - `req_ready` returns at edge 22.
  - General form: `freq_sel` at 1+VS; `done` at 1+VS+FS.
- Ack delayed by d cycles: every later event shifts by d.
- Downscale (defaults):
  - `freq_sel` changes at edge 0.
  - `volt_sel` changes at edge 4 (FS).
  - With ack at edge 5, `done` is asserted at edge 21 (FS+1+VS).
- Equal level: `done` at edge 0; IDLE at edge 1.
- Back-to-back: a new request can be accepted on the edge after DONE. Minimum gap is one IDLE cycle.
- Timeout: `err` rises at edge 1+TIMEOUT_CYCLES if no ack arrives; the same edge returns to IDLE.

## Structure
- Package `dvfs_pkg`:
  - 2-bit level type.
  - `LEVEL_MIN`=0 and `LEVEL_MAX`=3.
  - State enum.
  - Default settle/timeout constants.
  - Shared with `dvfs_controller`.
- Sub-module `dvfs_settle_timer`: loadable down-counter with `load`, `value`, and `expired` outputs. The V_SETTLE, F_WAIT and V_WAIT timeout paths reuse one instance; the width is sized to the largest parameter.

## Test plan
- Reset with level 0, request level 3, ack after 2 cycles → `volt_sel`=3 at edge 0, `freq_sel`=3 at edge 19, `done` at edge 23, `err`=0.
- From level 3 request level 1, ack immediately → `freq_sel`=1 at edge 0, `volt_sel`=1 at edge 4, `done` at edge 21. The invariant `volt_sel ≥ freq_sel` is checked every cycle.
- Request level 2 with `vreg_ack` held low → `err`=1 at edge 256, `freq_sel` unchanged, `volt_sel`=2, no `done`. The next accepted request clears `err`.
- Equal-level request, plus `req_valid` pulsed while busy → equal request gives `done` at edge 0 with no select change. The busy-time request is not accepted.
- Assert `reset` low mid-V_SETTLE and mid-F_WAIT → `freq_sel`=`volt_sel`=0, `busy`=0, `req_ready`=1, all immediately.
